// File: rtl/fir_coef_streamer.sv
// fir_coef_streamer
//
// Coefficient-load transmitter for the 7-tap FIR filters. Holds two
// host-programmable coefficient banks. On command it streams one bank as a
// framed burst on the writeen / coef_val / tlast load interface. An abort
// sends a single zero beat with tlast, so the receiver throws away the partial
// load and resynchronises its index.
//
// Handshake: a beat transfers on a rising clk edge where writeen && coef_ready.
// While writeen is high and coef_ready is low, coef_val and tlast hold.
// writeen never drops before its beat has transferred, except on reset.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   cfg_we          host write strobe, one coefficient per cycle
//   cfg_bank        bank select for the host write
//   cfg_addr        tap index for the host write (0..NTAPS-1)
//   cfg_data        coefficient value for the host write
//   cfg_err         one-cycle pulse in the cycle after a rejected write
//   start           request to stream a bank (level sampled in IDLE)
//   start_bank      bank to stream, captured with start
//   abort           terminate the current stream (honoured in SEND only)
//   coef_ready      consumer can accept a beat
//   writeen         beat valid
//   coef_val        beat data
//   tlast           final beat of the frame
//   busy            streamer is not idle
//   done            one-cycle pulse after a complete frame
//   aborted         one-cycle pulse after a terminating frame
//   dbg_state       current FSM state, for checkers
module fir_coef_streamer #(
    parameter int NTAPS = 7,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_bank,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic          cfg_err,
    input  logic          start,
    input  logic          start_bank,
    input  logic          abort,
    input  logic          coef_ready,
    output logic          writeen,
    output logic [DW-1:0] coef_val,
    output logic          tlast,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [1:0]    dbg_state
);

    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_TERM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic          r_bank;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_mem [2][NTAPS];
    logic          r_writeen;
    logic [DW-1:0] r_coef_val;
    logic          r_tlast;
    logic          r_busy;
    logic          r_done;
    logic          r_aborted;
    logic          r_cfg_err;

    logic          w_addr_ok;
    logic          w_streaming;
    logic          w_wr_ok;
    logic          w_wr_err;
    logic [IW-1:0] w_next_idx;
    logic [DW-1:0] w_first_val;

    assign w_addr_ok   = int'({1'b0, cfg_addr}) < NTAPS;
    // The active bank is locked only while beats are being emitted.
    assign w_streaming = (r_state == S_SEND) || (r_state == S_TERM);
    assign w_wr_ok     = cfg_we && w_addr_ok && !(w_streaming && (cfg_bank == r_bank));
    assign w_wr_err    = cfg_we && !w_wr_ok;
    assign w_next_idx  = r_idx + IW'(1);

    // A write landing in the start cycle must be seen by the first beat, so
    // forward it around the storage register.
    assign w_first_val = (w_wr_ok && (cfg_bank == start_bank) && (cfg_addr == 3'd0))
                         ? cfg_data : r_mem[start_bank][0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int t = 0; t < NTAPS; t++) begin
                    r_mem[b][t] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_mem[cfg_bank][cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bank     <= 1'b0;
            r_idx      <= '0;
            r_writeen  <= 1'b0;
            r_coef_val <= '0;
            r_tlast    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_wr_err;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_SEND;
                        r_bank     <= start_bank;
                        r_idx      <= '0;
                        r_writeen  <= 1'b1;
                        r_coef_val <= w_first_val;
                        r_tlast    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_SEND: begin
                    // Abort wins over a transfer in the same cycle; the
                    // presented beat is replaced by the terminating beat.
                    if (abort) begin
                        r_state    <= S_TERM;
                        r_coef_val <= '0;
                        r_tlast    <= 1'b1;
                    end else if (coef_ready) begin
                        if (r_tlast) begin
                            r_state    <= S_DONE;
                            r_writeen  <= 1'b0;
                            r_tlast    <= 1'b0;
                            r_coef_val <= '0;
                            r_done     <= 1'b1;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_coef_val <= r_mem[r_bank][w_next_idx];
                            r_tlast    <= (w_next_idx == IW'(NTAPS - 1));
                        end
                    end
                end
                S_TERM: begin
                    if (coef_ready) begin
                        r_state   <= S_IDLE;
                        r_writeen <= 1'b0;
                        r_tlast   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign writeen   = r_writeen;
    assign coef_val  = r_coef_val;
    assign tlast     = r_tlast;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign cfg_err   = r_cfg_err;
    assign dbg_state = r_state;

endmodule

// File: doc/fir_coef_streamer.md
# fir_coef_streamer

Coefficient-load transmitter for the 7-tap FIR filters. Holds two host-programmable coefficient banks and, on command, streams one bank as a framed burst on the `writeen` / `coef_val` / `tlast` load interface that the FIR filters receive. A `coef_ready` input provides optional backpressure; for FIR consumers without backpressure it is tied high. An abort emits a short terminating frame so that the receiver discards the partial load and resynchronises its index.

## Interface
Parameters:
- `NTAPS`, 7: coefficients per frame, must be ≥2.
- `DW`, 8: coefficient width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `cfg_we`  in  1: host write strobe, one coefficient per cycle.
- `cfg_bank`  in  1: bank select for the host write.
- `cfg_addr`  in  3: tap index for the host write. Valid range is 0..NTAPS-1.
- `cfg_data`  in  DW: coefficient value for the host write.
- `cfg_err`  out  1: one-cycle pulse when a host write is rejected.
- `start`  in  1: request to stream a bank. Level is sampled each cycle.
- `start_bank`  in  1: bank to stream, captured together with `start`.
- `abort`  in  1: terminate the current stream.
- `coef_ready`  in  1: consumer can accept a beat.
- `writeen`  out  1: beat valid.
- `coef_val`  out  DW: beat data.
- `tlast`  out  1: final beat of the frame.
- `busy`  out  1: streamer is not idle.
- `done`  out  1: one-cycle pulse after a complete frame.
- `aborted`  out  1: one-cycle pulse after a terminating frame.

## Operation
- Storage is 2×NTAPS registers, reset to 0.
- Host writes:
  - A write is accepted when `cfg_we` is high, `cfg_addr` < NTAPS, and the target bank is not the bank currently being streamed (active bank).
  - Any rejected write leaves storage unchanged and pulses `cfg_err` on the next cycle.
  - Writes to the inactive bank are always allowed.
- FSM states: IDLE, SEND, TERM, DONE.
  - IDLE: `start` = 1 captures `start_bank` as the active bank, clears the index, and moves to SEND. `abort` in IDLE is ignored.
  - SEND: `writeen` = 1 and `coef_val` = bank[active][idx]. `tlast` = (idx == NTAPS-1).
    - A beat transfers when `writeen` && `coef_ready`; idx then increments.
    - Transfer of the `tlast` beat moves to DONE.
    - `abort` = 1 in SEND has priority over a transfer that cycle and moves to TERM. That beat is not counted as sent.
  - TERM: one beat with `coef_val` = 0 and `tlast` = 1, held until `coef_ready`, then back to IDLE. `aborted` pulses 1 cycle after the transfer. `abort` in TERM is ignored.
  - DONE: `done` = 1 for one cycle, then IDLE. `start` in DONE is ignored.
- `start` while not IDLE is ignored. No queuing.
- Data stability: while `writeen` = 1 and `coef_ready` = 0, `coef_val` and `tlast` hold stable.
- `busy` = 1 in SEND, TERM and DONE.

## Timing
- All outputs are registered.
- Reset values: `writeen`, `tlast`, `busy`, `done`, `aborted` and `cfg_err` are 0; `coef_val` is 0; state is IDLE; idx is 0.
- Latency:
  - `start` sampled at edge E → first beat valid in the cycle after E.
  - With `coef_ready` held high, beats occupy NTAPS consecutive cycles (7 for the default). `tlast` is high in the last of them.
  - `done` is high in the following cycle.
  - IDLE is reached one cycle later. A new `start` is accepted at the edge ending the `done` cycle + 1.
- Stalls: each cycle with `coef_ready` = 0 during a beat extends the frame by one cycle. There are no bubbles when ready is high.
- Reset mid-frame: outputs drop to 0 immediately (asynchronously). No terminating beat is emitted; the consumer is reset alongside.
- Simultaneous host write and streaming:
  - A write to the active bank during SEND or TERM is rejected.
  - A write to the active bank in DONE or IDLE is accepted.
  - A write to the active bank's storage in the same cycle as `start` is accepted; the stream reads the updated value, because the write lands before the first beat.
- `cfg_err` is high in the cycle after the offending write.

## Test plan
- Program bank0 with 1..7 and start bank0 with `coef_ready` = 1 → `writeen` high for 7 cycles carrying 1,2,…,7, `tlast` only on 7, `done` one cycle later, `busy` low after. The FIR then reports valid coefficients.
- Same frame with `coef_ready` low on beats 3 and 5 for 2 cycles each → 11-cycle frame; values are held during stalls and the sequence is unchanged.
- Start bank1 (values 10..16), assert `abort` on the beat carrying 12 → one beat of 0 with `tlast`, `aborted` pulse, no `done`. The FIR sees `tlast` at index ≠ 6 and discards the load.
- During a bank0 stream: write bank0 addr 2 → `cfg_err` pulse and storage unchanged. Write bank1 addr 2 = 0x55 → accepted, no error. Write `cfg_addr` = 7 → `cfg_err`.
- `start` pulses during SEND and DONE → ignored, exactly one frame. `abort` in IDLE → no output activity.
- Assert `rst` on beat 4 → all outputs 0 immediately. A subsequent start resends the full 7 beats from index 0; storage is reset to 0 and must be reprogrammed.
